exec_sequencer: RTL

Multi-cycle execute-stage sequencer that drives the combinational `arith_logic_unit` from the decode stage. It accepts one decoded instruction per valid/ready handshake and registers the operands. It then presents the operands and op to the ALU for one cycle and captures `alu_dout` or `alu_comp`. Finally it either hands a result to writeback over a valid/ready handshake, or emits a one-cycle branch-resolution pulse.

---
 rtl/exec_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Multi-cycle execute-stage sequencer sitting between the decode stage and the
// combinational arith_logic_unit.  One decoded instruction is taken per
// dec_valid/dec_ready handshake and its operands are registered.  The ALU is
// driven from those registers for exactly one cycle.  After that cycle the
// sequencer either:
//   - holds an ALU result for writeback on a wb_valid/wb_ready handshake, or
//   - emits a one-cycle br_taken pulse with the resolved branch target.
//
// The copperv core defines the data width, ALU opcode width and ALU opcodes in
// copperv_h.v.  They are parameters here so the block stays self-contained.
//
// Optional feature macro:
//   EXEC_BRANCH_EN  defined   : BEQ/BNE are resolved (ALU SUB + alu_comp,
//                               dedicated pc+imm target adder).
//                   undefined : branch kinds are accepted, spend one EXEC cycle
//                               with a NOP on the ALU and retire silently;
//                               br_taken and br_target are tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   dec_valid / dec_ready     decode handshake (dec_ready never uses dec_valid)
//   dec_kind                  00 ALU reg-reg, 01 ALU reg-imm, 10 BEQ, 11 BNE
//   dec_alu_op                ALU opcode for ALU kinds (ignored for branches)
//   dec_rs1_data/rs2_data     source operands
//   dec_imm, dec_pc, dec_rd   immediate, instruction PC, destination index
//   alu_din1/din2/op          ALU operands and opcode (NOP/0 outside EXEC)
//   alu_dout, alu_comp        ALU result and equality flag
//   wb_valid/wb_ready         writeback handshake
//   wb_rd, wb_data            writeback payload, stable while stalled
//   br_taken, br_target       taken-branch pulse and its target
// -----------------------------------------------------------------------------
module exec_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = ALU_OP_WIDTH'(0),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = ALU_OP_WIDTH'(1),
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = ALU_OP_WIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [1:0]              dec_kind,
  input  logic [ALU_OP_WIDTH-1:0] dec_alu_op,
  input  logic [DATA_WIDTH-1:0]   dec_rs1_data,
  input  logic [DATA_WIDTH-1:0]   dec_rs2_data,
  input  logic [DATA_WIDTH-1:0]   dec_imm,
  input  logic [DATA_WIDTH-1:0]   dec_pc,
  input  logic [4:0]              dec_rd,
  output logic [DATA_WIDTH-1:0]   alu_din1,
  output logic [DATA_WIDTH-1:0]   alu_din2,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_dout,
  input  logic                    alu_comp,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [4:0]              wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    br_taken,
  output logic [DATA_WIDTH-1:0]   br_target
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Captured instruction.  Datapath registers carry no reset: they are only
  // consumed in EXEC, which is always preceded by a capture.
  logic [1:0]              kind_reg;
  logic [ALU_OP_WIDTH-1:0] op_reg;
  logic [DATA_WIDTH-1:0]   rs1_reg;
  logic [DATA_WIDTH-1:0]   rs2_reg;
  logic [DATA_WIDTH-1:0]   imm_reg;
  logic [4:0]              rd_reg;

  // Writeback payload
  logic [4:0]              wb_rd_reg;
  logic [DATA_WIDTH-1:0]   wb_data_reg;

  logic dec_accept;
  logic is_branch;
  logic exec_alu;

  assign is_branch  = kind_reg[1];
  assign exec_alu   = (state_reg == ST_EXEC) && !is_branch;
  assign dec_accept = dec_valid && dec_ready;

  // ---------------------------------------------------------------------------
  // Next state, handshake and ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    dec_ready  = 1'b0;
    alu_op     = ALU_OP_NOP;
    alu_din1   = '0;
    alu_din2   = '0;
    case (state_reg)
      ST_IDLE: begin
        dec_ready = 1'b1;
        if (dec_valid) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (!is_branch) begin
          alu_din1   = rs1_reg;
          alu_din2   = kind_reg[0] ? imm_reg : rs2_reg;
          alu_op     = op_reg;
          state_next = ST_HOLD;
        end else begin
`ifdef EXEC_BRANCH_EN
          // Equality comes from alu_comp; the opcode field is ignored.
          alu_din1 = rs1_reg;
          alu_din2 = rs2_reg;
          alu_op   = ALU_OP_SUB;
`endif
          state_next = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A retiring result frees the slot, so a new instruction can be
        // captured on the same edge.
        dec_ready = wb_ready;
        if (wb_ready) state_next = dec_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (dec_accept) begin
      kind_reg <= dec_kind;
      op_reg   <= dec_alu_op;
      rs1_reg  <= dec_rs1_data;
      rs2_reg  <= dec_rs2_data;
      imm_reg  <= dec_imm;
      rd_reg   <= dec_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // State and writeback registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (exec_alu) begin
        wb_rd_reg   <= rd_reg;
        // x0 is hardwired to zero, so its result is forced to 0.
        wb_data_reg <= (rd_reg == 5'd0) ? '0 : alu_dout;
      end
    end
  end

  assign wb_valid = (state_reg == ST_HOLD);
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;

  // ---------------------------------------------------------------------------
  // Branch resolution
  // ---------------------------------------------------------------------------
`ifdef EXEC_BRANCH_EN
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] br_sum;
  logic                  br_cond;
  logic                  br_taken_reg;
  logic [DATA_WIDTH-1:0] br_target_reg;

  always_ff @(posedge clk) begin
    if (dec_accept) pc_reg <= dec_pc;
  end

  // Dedicated adder; wraps modulo 2^DATA_WIDTH.
  assign br_sum  = pc_reg + imm_reg;
  // kind_reg[0]: 0 = BEQ (taken on equal), 1 = BNE (taken on not-equal)
  assign br_cond = kind_reg[0] ? !alu_comp : alu_comp;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_reg  <= 1'b0;
      br_target_reg <= '0;
    end else begin
      br_taken_reg <= 1'b0;
      // The target only moves on a taken branch, so a not-taken branch
      // leaves both outputs untouched.
      if ((state_reg == ST_EXEC) && is_branch && br_cond) begin
        br_taken_reg  <= 1'b1;
        br_target_reg <= br_sum;
      end
    end
  end

  assign br_taken  = br_taken_reg;
  assign br_target = br_target_reg;
`else
  // Without branch resolution the PC and the equality flag have no consumer.
  logic unused_branch_inputs;
  assign unused_branch_inputs = alu_comp ^ (^dec_pc);

  assign br_taken  = 1'b0;
  assign br_target = '0;
`endif

endmodule
